// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: compares operands, selects target or fall-through, and holds the outcome in a one-entry handshake register.
// Optional macro BRU_PERF_CNT_EN adds perf_branches/perf_taken counters.

// Unsigned less-than comparator built as a ripple borrow chain from the LSB up.
module set_less_than_unsigned (
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  output logic        o_lt
);
  logic [64:0] w_lt_chain;

  assign w_lt_chain[0] = 1'b0;

  genvar g;
  generate
    for (g = 0; g < 64; g = g + 1) begin : g_bit
      // A higher bit that differs overrides everything below it.
      assign w_lt_chain[g+1] = (~i_a[g] & i_b[g]) | (~(i_a[g] ^ i_b[g]) & w_lt_chain[g]);
    end
  endgenerate

  assign o_lt = w_lt_chain[64];
endmodule

// Invariants on the registered outcome of the branch resolver.
module branch_resolve_unit_chk #(
  parameter int XLEN = 64
) (
  input logic            i_clk,
  input logic            i_rst_n,
  input logic            i_flush,
  input logic            i_out_ready,
  input logic            i_out_valid,
  input logic            i_out_taken,
  input logic            i_out_illegal,
  input logic            i_out_misalign,
  input logic [XLEN-1:0] i_out_next_pc
);
  a_hold_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_out_valid && !i_out_ready && !i_flush) |=>
      (i_out_valid && $stable(i_out_next_pc) && $stable(i_out_taken)));

  a_flush_empties: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_flush |=> !i_out_valid);

  a_illegal_not_taken: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_out_illegal |-> !i_out_taken);

  a_misalign_taken: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_out_misalign |-> i_out_taken);
endmodule

module branch_resolve_unit #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_PC_INC = 64'd4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_next_pc,
  output logic            out_illegal,
  output logic            out_misalign
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_taken
`endif
);
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_taken;
  logic [XLEN-1:0] r_next_pc;
  logic            r_illegal;
  logic            r_misalign;

  logic            w_in_ready;
  logic            w_accept;
  logic            w_eq;
  logic            w_ltu;
  logic            w_lt;
  logic            w_taken;
  logic            w_illegal;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_fall;
  logic [XLEN-1:0] w_next_pc;
  logic            w_misalign;
  logic [XLEN-1:0] w_rs1_bias;
  logic [XLEN-1:0] w_rs2_bias;

  assign w_in_ready = (r_state == ST_EMPTY) | out_ready;
  assign w_accept   = in_valid & w_in_ready & ~flush;

  assign w_eq = (in_rs1 == in_rs2);

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  assign w_rs1_bias = {~in_rs1[XLEN-1], in_rs1[XLEN-2:0]};
  assign w_rs2_bias = {~in_rs2[XLEN-1], in_rs2[XLEN-2:0]};

  set_less_than_unsigned u_sltu (
    .i_a  (in_rs1),
    .i_b  (in_rs2),
    .o_lt (w_ltu)
  );

  set_less_than_unsigned u_slt (
    .i_a  (w_rs1_bias),
    .i_b  (w_rs2_bias),
    .o_lt (w_lt)
  );

  // Branch condition decode from funct3.
  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    case (in_funct3)
      3'b000:  w_taken = w_eq;
      3'b001:  w_taken = ~w_eq;
      3'b100:  w_taken = w_lt;
      3'b101:  w_taken = ~w_lt;
      3'b110:  w_taken = w_ltu;
      3'b111:  w_taken = ~w_ltu;
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_target   = in_pc + in_imm;
  assign w_fall     = in_pc + RESET_PC_INC;
  assign w_next_pc  = w_taken ? w_target : w_fall;
  assign w_misalign = w_taken & (w_target[1:0] != 2'b00);

  // Output register occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: flush wins; a drain with a simultaneous accept stays full.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) w_state_nxt = ST_FULL;
          else          w_state_nxt = ST_EMPTY;
        end
        ST_FULL: begin
          if (w_accept)       w_state_nxt = ST_FULL;
          else if (out_ready) w_state_nxt = ST_EMPTY;
          else                w_state_nxt = ST_FULL;
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Outcome data register; keeps stale values when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken    <= 1'b0;
      r_next_pc  <= {XLEN{1'b0}};
      r_illegal  <= 1'b0;
      r_misalign <= 1'b0;
    end else if (w_accept) begin
      r_taken    <= w_taken;
      r_next_pc  <= w_next_pc;
      r_illegal  <= w_illegal;
      r_misalign <= w_misalign;
    end else begin
      r_taken    <= r_taken;
      r_next_pc  <= r_next_pc;
      r_illegal  <= r_illegal;
      r_misalign <= r_misalign;
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [31:0] r_perf_branches;
  logic [31:0] r_perf_taken;

  // Event counters; wrap naturally and are untouched by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_branches <= 32'd0;
      r_perf_taken    <= 32'd0;
    end else begin
      if (w_accept & ~w_illegal) r_perf_branches <= r_perf_branches + 32'd1;
      else                       r_perf_branches <= r_perf_branches;
      if (w_accept & w_taken)    r_perf_taken    <= r_perf_taken + 32'd1;
      else                       r_perf_taken    <= r_perf_taken;
    end
  end

  assign perf_branches = r_perf_branches;
  assign perf_taken    = r_perf_taken;
`endif

  assign in_ready     = w_in_ready;
  assign out_valid    = (r_state == ST_FULL);
  assign out_taken    = r_taken;
  assign out_next_pc  = r_next_pc;
  assign out_illegal  = r_illegal;
  assign out_misalign = r_misalign;

  branch_resolve_unit_chk #(.XLEN(XLEN)) u_chk (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_flush        (flush),
    .i_out_ready    (out_ready),
    .i_out_valid    (out_valid),
    .i_out_taken    (out_taken),
    .i_out_illegal  (out_illegal),
    .i_out_misalign (out_misalign),
    .i_out_next_pc  (out_next_pc)
  );
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a spec-level outcome model checked every cycle plus hand-computed literal checks.
module tb_branch_resolve_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  logic [63:0] in_pc;
  logic [63:0] in_imm;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic [63:0] out_next_pc;
  logic        out_illegal;
  logic        out_misalign;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_taken;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_funct3    (in_funct3),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_pc        (in_pc),
    .in_imm       (in_imm),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_taken    (out_taken),
    .out_next_pc  (out_next_pc),
    .out_illegal  (out_illegal),
    .out_misalign (out_misalign)
`ifdef BRU_PERF_CNT_EN
    ,
    .perf_branches(perf_branches),
    .perf_taken   (perf_taken)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural meaning of a branch op, written with native signed/unsigned compares.
  function automatic void resolve(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                                  input logic [63:0] pc, input logic [63:0] imm,
                                  output logic taken, output logic illegal,
                                  output logic [63:0] npc, output logic misalign);
    logic [63:0] target;
    illegal = (f3 == 3'b010) || (f3 == 3'b011);
    case (f3)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = ($signed(a) <  $signed(b));
      3'b101:  taken = ($signed(a) >= $signed(b));
      3'b110:  taken = (a <  b);
      3'b111:  taken = (a >= b);
      default: taken = 1'b0;
    endcase
    target   = pc + imm;
    npc      = taken ? target : pc + 64'd4;
    misalign = taken && (target[1:0] != 2'b00);
  endfunction

  logic        m_valid    = 1'b0;
  logic        m_taken    = 1'b0;
  logic        m_illegal  = 1'b0;
  logic        m_misalign = 1'b0;
  logic [63:0] m_next_pc  = 64'd0;
  logic        m_acc      = 1'b0;
  int unsigned m_branches = 0;
  int unsigned m_tcount   = 0;

  // Reference model of the one-entry result slot.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_taken = 1'b0; m_illegal = 1'b0; m_misalign = 1'b0;
      m_next_pc = 64'd0; m_branches = 0; m_tcount = 0;
    end else begin
      m_acc = in_valid && (!m_valid || out_ready) && !flush;
      if (flush) begin
        m_valid = 1'b0;
      end else if (m_acc) begin
        resolve(in_funct3, in_rs1, in_rs2, in_pc, in_imm, m_taken, m_illegal, m_next_pc, m_misalign);
        m_valid = 1'b1;
        if (!m_illegal) m_branches++;
        if (m_taken)    m_tcount++;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, just after each rising edge.
  always @(posedge clk) begin
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    chk("in_ready", {63'd0, in_ready}, {63'd0, (!m_valid || out_ready)});
    if (m_valid) begin
      chk("out_taken", {63'd0, out_taken}, {63'd0, m_taken});
      chk("out_next_pc", out_next_pc, m_next_pc);
      chk("out_illegal", {63'd0, out_illegal}, {63'd0, m_illegal});
      chk("out_misalign", {63'd0, out_misalign}, {63'd0, m_misalign});
    end
`ifdef BRU_PERF_CNT_EN
    chk("perf_branches", {32'd0, perf_branches}, {32'd0, m_branches});
    chk("perf_taken", {32'd0, perf_taken}, {32'd0, m_tcount});
`endif
  end

  task automatic op(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                    input logic [63:0] pc, input logic [63:0] imm);
    in_valid = 1'b1; in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_pc = pc; in_imm = imm;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [2:0]  f3_tab [8];
  logic [15:0] rdy_pat;
  logic [63:0] va;
  logic [63:0] vb;

  initial begin
    f3_tab = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
    rdy_pat = 16'b1011_0111_1100_1101;
    rst_n = 1'b0; in_valid = 1'b0; in_funct3 = 3'b000; in_rs1 = 64'd0; in_rs2 = 64'd0;
    in_pc = 64'd0; in_imm = 64'd0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_taken", {63'd0, out_taken}, 64'd0);
    chk("rst_next_pc", out_next_pc, 64'd0);
    chk("rst_illegal", {63'd0, out_illegal}, 64'd0);
    chk("rst_misalign", {63'd0, out_misalign}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Unsigned vs signed split on the same operands.
    op(3'b110, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1000, 64'h40);
    tick();
    chk("bltu_valid", {63'd0, out_valid}, 64'd1);
    chk("bltu_taken", {63'd0, out_taken}, 64'd1);
    chk("bltu_npc", out_next_pc, 64'h1040);
    op(3'b100, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1000, 64'h40);
    tick();
    chk("blt_taken", {63'd0, out_taken}, 64'd0);
    chk("blt_npc", out_next_pc, 64'h1004);

    // Equal operands with only the sign bit set.
    op(3'b000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h3000, 64'h100);
    tick();
    chk("beq_taken", {63'd0, out_taken}, 64'd1);
    op(3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h3000, 64'h100);
    tick();
    chk("bne_taken", {63'd0, out_taken}, 64'd0);
    op(3'b101, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h3000, 64'h100);
    tick();
    chk("bge_taken", {63'd0, out_taken}, 64'd1);
    op(3'b111, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h3000, 64'h100);
    tick();
    chk("bgeu_taken", {63'd0, out_taken}, 64'd1);

    // Illegal funct3, misaligned target, and address wrap.
    op(3'b010, 64'h5, 64'h5, 64'h4000, 64'h8);
    tick();
    chk("ill_flag", {63'd0, out_illegal}, 64'd1);
    chk("ill_taken", {63'd0, out_taken}, 64'd0);
    chk("ill_npc", out_next_pc, 64'h4004);
    op(3'b000, 64'h7, 64'h7, 64'h2000, 64'h6);
    tick();
    chk("mis_flag", {63'd0, out_misalign}, 64'd1);
    chk("mis_npc", out_next_pc, 64'h2006);
    op(3'b000, 64'h1, 64'h1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20);
    tick();
    chk("wrap_npc", out_next_pc, 64'h10);
    chk("wrap_mis", {63'd0, out_misalign}, 64'd0);

    // Backpressure: hold A for five cycles, then swap to B without a bubble.
    op(3'b001, 64'h3, 64'h4, 64'h5000, 64'h80);
    tick();
    out_ready = 1'b0;
    op(3'b000, 64'h9, 64'h9, 64'h6000, 64'h10);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_npc_hold", out_next_pc, 64'h5080);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_swap_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_swap_npc", out_next_pc, 64'h6010);

    // Flush while full with a pending input and no downstream ready.
    out_ready = 1'b0; flush = 1'b1;
    op(3'b001, 64'h1, 64'h2, 64'h7000, 64'h20);
    tick();
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("flush_dropped", {63'd0, out_valid}, 64'd0);

    // Mixed burst with a fixed ready pattern, checked by the model.
    for (int i = 0; i < 16; i++) begin
      va = 64'h8000_0000_0000_0000 ^ (64'(i) * 64'h0123_4567_89AB_CDEF);
      vb = (i % 3 == 0) ? va : (64'(i) * 64'hFEDC_BA98_7654_3211);
      op(f3_tab[i % 8], va, vb, 64'h1_0000 + 64'(i) * 64'd4, 64'(i) * 64'h12 - 64'h40);
      out_ready = rdy_pat[i];
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();

    // Asynchronous reset between clock edges.
    op(3'b000, 64'h2, 64'h2, 64'h8000, 64'h40);
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_npc", out_next_pc, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Counter scenario: 3 taken, 2 not taken, 1 illegal, 1 flushed.
    op(3'b000, 64'h1, 64'h1, 64'h100, 64'h8); tick();
    op(3'b001, 64'h1, 64'h2, 64'h100, 64'h8); tick();
    op(3'b110, 64'h1, 64'h2, 64'h100, 64'h8); tick();
    op(3'b000, 64'h1, 64'h2, 64'h100, 64'h8); tick();
    op(3'b111, 64'h1, 64'h2, 64'h100, 64'h8); tick();
    op(3'b011, 64'h1, 64'h2, 64'h100, 64'h8); tick();
    flush = 1'b1;
    op(3'b000, 64'h1, 64'h1, 64'h100, 64'h8); tick();
    flush = 1'b0; in_valid = 1'b0;
    tick();
`ifdef BRU_PERF_CNT_EN
    chk("perf_branches_lit", {32'd0, perf_branches}, 64'd5);
    chk("perf_taken_lit", {32'd0, perf_taken}, 64'd3);
`endif
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage branch resolver for the 64-bit RISC-V core; consumes decoded branch ops from the issue stage and produces a registered branch outcome for the fetch/PC-select logic.
- Uses the team's gate-level `set_less_than_unsigned` comparator for the BLTU/BGEU outcome.
- Derives the signed BLT/BGE outcome from that comparator by inverting both operand MSBs.
- One-entry output register with a valid/ready handshake on both sides, plus a flush input for pipeline redirects.

Parameters:
- XLEN, 64, operand/PC width; only 64 is supported, because the comparator is fixed at 64 bits.
- RESET_PC_INC, 4, value added to pc to form the fall-through address.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents a branch op.
- in_ready  output  1  unit can accept this cycle.
- in_funct3  input  3  RISC-V branch funct3.
- in_rs1  input  XLEN  operand A.
- in_rs2  input  XLEN  operand B.
- in_pc  input  XLEN  PC of the branch.
- in_imm  input  XLEN  sign-extended B-immediate.
- flush  input  1  kill held and incoming ops.
- out_valid  output  1  result register holds a valid outcome.
- out_ready  input  1  downstream accepts the outcome.
- out_taken  output  1  branch taken.
- out_next_pc  output  XLEN  taken ? pc+imm : pc+4.
- out_illegal  output  1  funct3 was 010 or 011.
- out_misalign  output  1  taken and target[1:0] != 0.

Behaviour:
- Reset (async, rst_n=0): state EMPTY; out_valid=0, out_taken=0, out_next_pc=0, out_illegal=0, out_misalign=0; perf counters 0.
- States:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- in_ready = ~out_valid | out_ready (combinational; permits back-to-back accepts).
- Accept = in_valid & in_ready & ~flush. On accept, all outputs load at the next clk edge: latency 1 cycle, throughput 1 op/cycle.
- Transitions:
  - EMPTY: accept -> FULL.
  - FULL: out_ready & ~accept -> EMPTY.
  - FULL: out_ready & accept -> FULL with new data.
  - FULL: ~out_ready -> hold FULL; all outputs stable, in_ready=0.
- Compare rules:
  - eq = (rs1 == rs2).
  - ltu = sltu(rs1, rs2).
  - lt = sltu({~rs1[63], rs1[62:0]}, {~rs2[63], rs2[62:0]}).
- Branch decode by funct3:
  - 000 -> eq; 001 -> ~eq.
  - 100 -> lt; 101 -> ~lt.
  - 110 -> ltu; 111 -> ~ltu.
  - 010/011 -> taken=0, illegal=1.
- Address arithmetic:
  - target = pc + imm, modulo 2^64 (wrap, no overflow flag).
  - Fall-through = pc + RESET_PC_INC, modulo 2^64.
- out_misalign = taken & (target[1:0] != 2'b00); out_next_pc still reports the target.
- Flush (synchronous) has priority over everything except reset.
  - Next edge: state EMPTY, out_valid=0.
  - A same-cycle input is dropped; a same-cycle out_ready handshake is not counted.
  - Data outputs may retain stale values when out_valid=0.
- Reset asserted mid-operation: immediate return to the reset state, independent of clk.
- Outputs are driven only from registers, never combinationally from in_*.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- Defined: adds output perf_branches[31:0] and output perf_taken[31:0].
  - perf_branches increments on every accept with a legal funct3.
  - perf_taken increments on accepts that resolve taken.
  - Both wrap at 2^32 and are cleared by rst_n only, not by flush.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- BLTU signed/unsigned split: funct3=110, rs1=0x0000000000000001, rs2=0xFFFFFFFFFFFFFFFF, pc=0x1000, imm=0x40 -> next cycle out_valid=1, taken=1, next_pc=0x1040. Same operands with funct3=100 (BLT) -> taken=0, next_pc=0x1004.
- BEQ/BNE on equal operands: rs1=rs2=0x8000000000000000 -> BEQ taken=1, BNE taken=0. Same equal operands with BGE -> taken=1; with BGEU -> taken=1.
- Backpressure: hold out_ready=0 after one accept -> in_ready=0, outputs frozen for 5 cycles. Raise out_ready with in_valid=1 -> handshake out and new op loaded on the same edge, no bubble.
- Illegal and misaligned: funct3=010 -> illegal=1, taken=0, next_pc=pc+4. BEQ taken with pc=0x2000, imm=0x6 -> misalign=1, next_pc=0x2006. pc=0xFFFFFFFFFFFFFFF0, imm=0x20 taken -> next_pc=0x10 (wrap).
- Flush priority: while FULL, assert flush with in_valid=1 and out_ready=0 -> next cycle out_valid=0 and the op is dropped. Assert rst_n=0 mid-stream with no clk edge -> out_valid=0 immediately.
- With BRU_PERF_CNT_EN: 3 taken + 2 not-taken + 1 illegal accepts -> perf_branches=5, perf_taken=3. A flushed input does not count.
